segment_scan_controller: RTL
============================

SEGMENT_SCAN_CONTROLLER -- requirements
Module: segment_scan_controller

Interface
REQ-001 Parameter DIV_WIDTH, default 18: scan tick once every 2^DIV_WIDTH clk cycles (bench uses 2).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ena  input  1  write strobe; data_in captured on any clk edge where ena=1.
REQ-005 data_in  input  32  display word from bus.
REQ-006 SW  input  1  half select: 0 shows word[15:0], 1 shows word[31:16].
REQ-007 wr_ack  output  1  one-cycle acknowledge of a write.
REQ-008 AN  output  4  digit anodes, active-low, one-hot-low when lit.
REQ-009 data_out  output  8  segments, active-low, bit7=DP, bits[6:0]=g..a.

Function
REQ-010 Prescaler: DIV_WIDTH-bit up-counter, wraps; tick=1 in the cycle count==all-ones.
REQ-011 Digit index: 2-bit, advances +1 mod 4 on tick only; 3->0 is the frame boundary.
REQ-012 Write path: ena=1 loads pending_reg<=data_in and sets pending_valid; wr_ack=1 in the next cycle only.
REQ-013 Back-to-back ena: every write acknowledged one cycle later; last write wins in pending_reg.
REQ-014 Commit: on frame-boundary tick, if pending_valid, shown_reg<=pending_reg and pending_valid cleared; SW sampled into sel_reg on every frame-boundary tick.
REQ-015 ena in the same cycle as a frame-boundary tick: previous pending value commits; new data stays pending until next boundary; pending_valid remains 1.
REQ-016 Displayed halfword H = sel_reg ? shown_reg[31:16] : shown_reg[15:0]; digit i shows H[4i+3:4i], digit 0 rightmost.
REQ-017 AN and data_out registered, updated on tick only; AN = ~(1<<i) for new digit i; data_out decoded from new digit and new committed values in same edge (no frame of stale data).
REQ-018 Hex decode (DP off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-019 SW changes mid-frame have no effect until next boundary; display never mixes halves within a frame.
REQ-020 No combinational path from any input to any output.

Reset
REQ-021 rst=1 immediately forces: prescaler 0, digit index 3, shown_reg 0, pending_reg 0, pending_valid 0, sel_reg 0, wr_ack 0, AN=4'b1111, data_out=8'hFF.
REQ-022 First tick after reset release is a frame boundary: digit 0 lit (AN=1110, data_out=C0 if no write).
REQ-023 rst mid-frame or with write pending: pending data discarded, no wr_ack issued afterwards.

Verification (DIV_WIDTH=2)
REQ-024 Reset release, no writes -> AN=1111/data_out=FF for 3 cycles, then AN cycles 1110,1101,1011,0111 every 4 cycles, data_out=C0 each digit.
REQ-025 ena with data_in=32'h0000_1234 mid-frame, SW=0 -> wr_ack 1 next cycle; display unchanged until boundary, then digits 0..3 show 99,B0,A4,F9.
REQ-026 data_in=32'hABCD_0000, SW 0->1 mid-frame -> current frame keeps old half; next frame shows 83?no: digit0 A1(d), digit1 C6(C), digit2 83(b), digit3 88(A).
REQ-027 ena exactly on boundary tick with 32'h0000_FFFF after earlier pending 32'h0000_0000 -> frame shows C0 x4, following frame 8E x4.
REQ-028 Three consecutive ena cycles (values 1,2,3) -> three wr_ack pulses offset by one cycle; next frame digit0=B0.
REQ-029 rst asserted with write pending and digit 2 lit -> outputs FF/1111 same cycle, no wr_ack, post-reset frame shows C0.

Source files
------------

// File: rtl/segment_scan_controller.sv
// segment_scan_controller
//   Multiplexed 4-digit, 7-segment scan driver with a double-buffered
//   32-bit display word. Bus writes land in a pending buffer. They are
//   promoted to the shown word only at a frame boundary, so a frame never
//   mixes old and new data or the two halfwords.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       asynchronous, active-high reset
//   ena       write strobe; data_in is captured on every edge with ena=1
//   data_in   32-bit display word
//   SW        halfword select (0: word[15:0], 1: word[31:16]), sampled at frame boundary
//   wr_ack    one-cycle acknowledge, one cycle after each write
//   AN        digit anodes, active-low, one-hot-low when lit
//   data_out  segments, active-low, bit7=DP, bits[6:0]=g..a
//
// Parameter
//   DIV_WIDTH prescaler width; one scan tick every 2^DIV_WIDTH clocks

module segment_scan_controller #(
  parameter int DIV_WIDTH = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] data_in,
  input  logic        SW,
  output logic        wr_ack,
  output logic [3:0]  AN,
  output logic [7:0]  data_out
);

  logic [DIV_WIDTH-1:0] presc;
  logic [1:0]           digit_idx;
  logic [31:0]          pending_reg;
  logic                 pending_valid;
  logic [31:0]          shown_reg;
  logic                 sel_reg;

  logic                 tick;
  logic                 boundary;
  logic [1:0]           idx_next;
  logic [31:0]          shown_next;
  logic                 sel_next;
  logic [15:0]          half_next;
  logic [3:0]           nib_next;
  logic [7:0]           seg_next;
  logic [3:0]           an_next;

  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Digit index starts at 3 out of reset, so the first tick is a boundary.
  // The display registers are decoded from the post-edge values of the
  // index, shown word and select. This keeps a freshly committed word from
  // appearing one digit late.
  always_comb begin
    tick       = &presc;
    boundary   = tick && (digit_idx == 2'd3);
    idx_next   = digit_idx + 2'd1;
    shown_next = (boundary && pending_valid) ? pending_reg : shown_reg;
    sel_next   = boundary ? SW : sel_reg;
    half_next  = sel_next ? shown_next[31:16] : shown_next[15:0];
    nib_next   = half_next[{idx_next, 2'b00} +: 4];
    seg_next   = hex_to_seg(nib_next);
    an_next    = ~(4'b0001 << idx_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      digit_idx <= 2'd3;
    end else begin
      presc <= presc + DIV_WIDTH'(1);
      if (tick) digit_idx <= idx_next;
    end
  end

  // When a write and a boundary coincide, the old pending word commits.
  // The new word becomes pending, so pending_valid stays set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg   <= '0;
      pending_valid <= 1'b0;
      wr_ack        <= 1'b0;
    end else begin
      wr_ack <= ena;
      if (ena) begin
        pending_reg   <= data_in;
        pending_valid <= 1'b1;
      end else if (boundary) begin
        pending_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown_reg <= '0;
      sel_reg   <= 1'b0;
    end else begin
      shown_reg <= shown_next;
      sel_reg   <= sel_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN       <= 4'b1111;
      data_out <= 8'hFF;
    end else if (tick) begin
      AN       <= an_next;
      data_out <= seg_next;
    end
  end

endmodule
